// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BR,
    SEL_JMP,
    SEL_RET,
    SEL_EXC
  } next_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

  // Targets are carried at the widest supported PC width; callers take the low bits.
  localparam int unsigned ALIGN_MAX_WIDTH = 64;

  function automatic logic [ALIGN_MAX_WIDTH-1:0] clear_low_bits(
    input logic [ALIGN_MAX_WIDTH-1:0] target,
    input int unsigned                inc
  );
    return target & ~(ALIGN_MAX_WIDTH'(inc) - ALIGN_MAX_WIDTH'(1));
  endfunction

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// the count saturates at RAS_DEPTH and the pointer wraps modulo RAS_DEPTH.
module ras_stack #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_replace,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr is the next free slot, so the top entry sits one below it.
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(RAS_DEPTH));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!o_full) r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end else if (i_replace && o_empty) begin
      r_count <= CNT_W'(1);
    end
  end

  // NOTE: the entry array has no reset; only the pointer and count define
  // which entries are valid, and leaving storage unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (!i_clear) begin
      if (i_push)         r_mem[r_ptr]     <= i_push_data;
      else if (i_replace) r_mem[w_top_idx] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: priority next-PC mux, PC/EPC registers and
// redirect flag. Optional return-address stack enabled by PC_GEN_RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             redirect,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam logic [ALIGN_MAX_WIDTH-1:0] ALIGN_MASK_WIDE = clear_low_bits('1, INC);
  localparam logic [WIDTH-1:0]           ALIGN_MASK      = ALIGN_MASK_WIDE[WIDTH-1:0];
  localparam logic [WIDTH-1:0]           INC_W           = WIDTH'(INC);

`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_redirect;

  next_sel_e        w_sel;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_redirect_next;
  logic             w_ras_push;
  logic             w_ras_pop;
  logic             w_ras_replace;
  logic             w_ras_empty;
  logic [WIDTH-1:0] w_ras_top;

  assign pc_out      = r_pc;
  assign pc_plus_inc = r_pc + INC_W;
  assign redirect    = r_redirect;
  assign epc         = r_epc;
  assign ras_empty   = w_ras_empty;

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the if/case chain leaves it unassigned (no latch).
  always_comb begin
    w_sel         = SEL_SEQ;
    w_ras_push    = 1'b0;
    w_ras_pop     = 1'b0;
    w_ras_replace = 1'b0;
    if (exc) begin
      w_sel = SEL_EXC;
    end else if (stall) begin
      w_sel = SEL_HOLD;
    end else if (br_taken) begin
      // A same-cycle jump belongs to a younger instruction being squashed.
      w_sel = SEL_BR;
    end else if (jump) begin
      w_sel = SEL_JMP;
      if (RAS_EN) begin
        if (call && ret) begin
          w_ras_replace = 1'b1;
          if (!w_ras_empty) w_sel = SEL_RET;
        end else if (ret) begin
          if (!w_ras_empty) begin
            w_ras_pop = 1'b1;
            w_sel     = SEL_RET;
          end
        end else if (call) begin
          w_ras_push = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pc_next = pc_plus_inc;
    case (w_sel)
      SEL_HOLD: w_pc_next = r_pc;
      SEL_BR:   w_pc_next = br_target & ALIGN_MASK;
      SEL_JMP:  w_pc_next = jump_target & ALIGN_MASK;
      SEL_RET:  w_pc_next = w_ras_top & ALIGN_MASK;
      SEL_EXC:  w_pc_next = EXC_VECTOR & ALIGN_MASK;
      default:  w_pc_next = pc_plus_inc;
    endcase
  end

  assign w_redirect_next = (w_sel == SEL_EXC) || (w_sel == SEL_BR) ||
                           (w_sel == SEL_JMP) || (w_sel == SEL_RET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_epc      <= '0;
      r_redirect <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_redirect <= w_redirect_next;
      if (exc) r_epc <= r_pc;
    end
  end

`ifdef PC_GEN_RAS_EN
  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk         (clk),
    .i_reset     (reset),
    .i_push      (w_ras_push),
    .i_pop       (w_ras_pop),
    .i_replace   (w_ras_replace),
    .i_clear     (exc),
    .i_push_data (pc_plus_inc),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (ras_full)
  );
`else
  logic w_unused_ras;

  assign w_ras_empty  = 1'b1;
  assign ras_full     = 1'b0;
  assign w_ras_top    = '0;
  assign w_unused_ras = ^{call, ret, w_ras_push, w_ras_pop, w_ras_replace};
`endif

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS fetch stage, replacing the bare PC register. It holds the fetch PC and selects the next PC each cycle from sequential increment, branch, jump, return and exception sources in fixed priority, with stall hold. An optional return-address stack (RAS) predicts `jr $ra` targets. It also captures the exception PC.

## Interface
- `WIDTH`, 32, PC width in bits.
- `RESET_VECTOR`, 0, PC value loaded on reset.
- `EXC_VECTOR`, 32'h0000_0080, PC value loaded on exception.
- `INC`, 4, sequential increment; must be a power of two.
- `RAS_DEPTH`, 4, RAS entries; must be ≥2 and a power of two.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: 1 holds the PC (hazard unit).
- `exc` in 1: exception redirect.
- `br_taken` in 1: resolved taken branch (EX stage).
- `br_target` in WIDTH: branch target.
- `jump` in 1: J/JAL/JR decoded in ID.
- `jump_target` in WIDTH: jump target (J/JAL/JR).
- `call` in 1: qualifies `jump` as JAL; pushes the return address.
- `ret` in 1: qualifies `jump` as `jr $ra`.
- `pc_out` out WIDTH: current fetch PC.
- `pc_plus_inc` out WIDTH: `pc_out + INC` (combinational).
- `redirect` out 1: the current `pc_out` came from a non-sequential load.
- `epc` out WIDTH: PC captured at the last exception.
- `ras_empty` out 1: RAS holds no entries.
- `ras_full` out 1: RAS holds `RAS_DEPTH` entries.

## Operation
- Next-PC priority, highest first:
  - reset
  - `exc`
  - `stall` (hold)
  - `br_taken`
  - `jump`
  - sequential
- `exc`:
  - Loads `EXC_VECTOR` even if `stall` is set.
  - Sets `epc <= pc_out`.
  - Clears the RAS (count = 0, pointer = 0).
- `stall` with no `exc`: PC, RAS and `epc` all hold; `redirect` drops to 0.
- `br_taken`:
  - Loads `br_target`.
  - Any same-cycle `jump`/`call`/`ret` comes from a younger instruction: it is ignored and the RAS is unchanged.
- `jump` alone: loads `jump_target`.
- `jump` with `call`:
  - Loads `jump_target`.
  - Pushes `pc_plus_inc`; this is the JAL return address as seen by fetch.
- `jump` with `ret`:
  - If the RAS is non-empty: pops and loads the popped entry.
  - If the RAS is empty: loads `jump_target`, and the count stays 0.
- `call` and `ret` together with `jump`:
  - Target is the top-of-stack entry, or `jump_target` if the RAS is empty.
  - The top entry is then replaced by `pc_plus_inc`; the count is unchanged, or becomes 1 if it was empty.
- `call`/`ret` without `jump`: ignored.
- RAS is circular:
  - A push when full overwrites the oldest entry; the count saturates at `RAS_DEPTH`.
  - The pointer wraps modulo `RAS_DEPTH`.
- Arithmetic:
  - All additions wrap modulo 2^WIDTH.
  - Every loaded target has its low log2(`INC`) bits forced to 0.
- Reset values:
  - `pc_out` = `RESET_VECTOR`
  - `epc` = 0
  - `redirect` = 0
  - RAS count = 0 and pointer = 0, so `ras_empty` = 1 and `ras_full` = 0
  - RAS entries are not reset.

## Timing
- All state updates on the rising edge of `clk`; latency from a select input to `pc_out` is 1 cycle.
- `redirect` is registered. It is 1 in the cycle where `pc_out` holds an exception, branch, jump or return target, and 0 after a sequential load, a stall or reset.
- `ras_empty` and `ras_full` reflect the registered count and update in the cycle after a push or pop.
- Reset asserted mid-operation forces the reset values immediately (asynchronous); the first load after deassertion is `RESET_VECTOR + INC`, unless the inputs select otherwise.
- Inputs are sampled only at the clock edge; no combinational path from inputs to `pc_out`.

## Configuration
- `PC_GEN_RAS_EN` defined:
  - RAS and the `ret` prediction are built as described.
- `PC_GEN_RAS_EN` undefined:
  - No RAS storage is built.
  - `call` and `ret` are ignored, so every `jump` loads `jump_target`.
  - `ras_empty` is tied to 1 and `ras_full` to 0.
  - All other behaviour is identical.

## Structure
- Package `pc_pkg`:
  - next-PC select enum: `SEL_SEQ`, `SEL_HOLD`, `SEL_BR`, `SEL_JMP`, `SEL_RET`, `SEL_EXC`
  - default `RESET_VECTOR` and `EXC_VECTOR` constants
  - a function that clears the low log2(`INC`) bits of a target.
- Sub-module `ras_stack`:
  - parameters `WIDTH` and `RAS_DEPTH`
  - inputs: push, pop, replace, clear, push data
  - outputs: top, empty, full
  - instantiated only under `PC_GEN_RAS_EN`.
- The top level holds the priority mux, the PC and `epc` registers, and the `redirect` flop.

## Test plan
- Reset asserted mid-cycle, then released; 3 idle cycles → `pc_out` goes to 0 asynchronously, then 4, 8, 12; `redirect` = 0.
- `br_taken` = 1, `br_target` = 0x103, with `jump` = 1 in the same cycle → next `pc_out` = 0x100, `redirect` = 1, RAS count unchanged.
- `stall` = 1 together with `exc` = 1 at `pc_out` = 0x40 → `pc_out` = 0x80, `epc` = 0x40, `ras_empty` = 1.
- Five JAL calls (`jump` + `call`) at PCs 0x10, 0x20, 0x30, 0x40, 0x50 with `RAS_DEPTH` = 4, then five `ret` → returns 0x54, 0x44, 0x34, 0x24, then `jump_target` for the fifth; `ras_full` is set after the 4th push and `ras_empty` after the 4th pop.
- `stall` held for 3 cycles during a `jump` + `call` request → PC and RAS frozen, `redirect` = 0; the jump and push take effect in the first unstalled cycle.
- Build without `PC_GEN_RAS_EN`, push then `ret` with `jump_target` = 0x200 → `pc_out` = 0x200, `ras_empty` stays 1.
